if_stage_pipe: RTL and testbench

//  Instruction-fetch stage of the 5-stage ARM pipeline, directly upstream of IDStage.

---
 rtl/arm_pkg.sv | 15 +
 rtl/instr_mem.sv | 19 +
 rtl/if_stage_pipe.sv | 78 +++++++
 tb/tb_if_stage_pipe.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared constants and types for the ARM pipeline stages.
// The IF/ID pipeline register is kept as one packed struct so it moves as a unit.
package arm_pkg;

  localparam int          INSTR_W    = 32;
  localparam int unsigned WORD_BYTES = 4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hE1A0_0000;  // MOV r0,r0

  typedef struct packed {
    logic [31:0]        pc;     // address of the fetched instruction + 4
    logic [INSTR_W-1:0] instr;
    logic               valid;  // 0 marks a bubble
  } if_id_t;

endpackage

// File: rtl/instr_mem.sv
// Instruction ROM with an asynchronous read port; contents are preloaded hierarchically.
// Word indices at or beyond IMEM_DEPTH read back as a NOP.
module instr_mem
  import arm_pkg::*;
#(
  parameter int    IMEM_DEPTH = 1024,
  parameter string INIT_FILE  = "instr.mem",
  parameter int    ADDR_W     = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1
) (
  input  logic [ADDR_W-1:0]  addr,
  output logic [INSTR_W-1:0] data
);

  // NOTE: ROM contents are never reset; they come only from the preload.
  logic [INSTR_W-1:0] mem [IMEM_DEPTH];

  assign data = (int'(addr) < IMEM_DEPTH) ? mem[addr] : NOP_INSTR;

endmodule

// File: rtl/if_stage_pipe.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID register and fetch counter.
// Branch redirect beats freeze; freeze holds everything; otherwise fetch sequentially.
module if_stage_pipe
  import arm_pkg::*;
#(
  parameter int          IMEM_DEPTH = 1024,
  parameter string       INIT_FILE  = "instr.mem",
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               branchTaken,
  input  logic [31:0]        branchAddr,
  output logic [31:0]        PC,
  output logic [INSTR_W-1:0] instruction,
  output logic               valid,
  output logic [31:0]        fetchCount
);

  localparam int ADDR_W = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

  logic [31:0]        pc_reg;
  logic [31:0]        pc_plus4;
  logic [31:0]        pc_next;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic               advance;
  logic               unused_addr_bits;
  if_id_t             if_id;
  if_id_t             if_id_next;

  assign imem_addr        = pc_reg[ADDR_W+1:2];
  assign unused_addr_bits = ^branchAddr[1:0];  // misaligned targets are silently aligned

  instr_mem #(
    .IMEM_DEPTH (IMEM_DEPTH),
    .INIT_FILE  (INIT_FILE),
    .ADDR_W     (ADDR_W)
  ) u_imem (
    .addr (imem_addr),
    .data (imem_data)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pc_plus4   = pc_reg + WORD_BYTES;
    pc_next    = pc_reg;
    if_id_next = if_id;
    advance    = 1'b0;
    if (branchTaken) begin
      pc_next    = {branchAddr[31:2], 2'b00};
      if_id_next = '{pc: 32'h0, instr: NOP_INSTR, valid: 1'b0};
    end else if (!freeze) begin
      pc_next    = pc_plus4;
      if_id_next = '{pc: pc_plus4, instr: imem_data, valid: 1'b1};
      advance    = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_reg     <= RESET_PC;
      if_id      <= '0;
      fetchCount <= '0;
    end else begin
      pc_reg <= pc_next;
      if_id  <= if_id_next;
      if (advance) fetchCount <= fetchCount + 32'd1;
    end
  end

  assign PC          = if_id.pc;
  assign instruction = if_id.instr;
  assign valid       = if_id.valid;

endmodule

// File: tb/tb_if_stage_pipe.sv
// Bench for if_stage_pipe: directed scenarios followed by random freeze/branch traffic,
// each edge compared against a behavioural fetch model.
module tb_if_stage_pipe;
  import arm_pkg::*;

  localparam int DEPTH    = 24;  // deliberately not a power of two
  localparam int IDX_SPAN = 32;  // word indices reachable through the ROM address bits

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branchTaken;
  logic [31:0] branchAddr;
  logic [31:0] PC;
  logic [31:0] instruction;
  logic        valid;
  logic [31:0] fetchCount;

  int errors = 0;
  int checks = 0;

  logic [31:0] rom [DEPTH];
  logic [31:0] m_pc_reg, m_pc, m_instr, m_count;
  logic        m_valid;

  always #5 clk = ~clk;

  if_stage_pipe #(
    .IMEM_DEPTH (DEPTH),
    .INIT_FILE  (""),
    .RESET_PC   (32'h0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .freeze      (freeze),
    .branchTaken (branchTaken),
    .branchAddr  (branchAddr),
    .PC          (PC),
    .instruction (instruction),
    .valid       (valid),
    .fetchCount  (fetchCount)
  );

  function automatic logic [31:0] fetch_word(input logic [31:0] byte_addr);
    logic [31:0] idx;
    idx = (byte_addr / 32'd4) % 32'(IDX_SPAN);
    return (idx < 32'(DEPTH)) ? rom[idx] : NOP_INSTR;
  endfunction

  task automatic model_reset();
    m_pc_reg = 32'h0;
    m_pc     = 32'h0;
    m_instr  = 32'h0;
    m_valid  = 1'b0;
    m_count  = 32'h0;
  endtask

  task automatic model_edge(input logic f, input logic b, input logic [31:0] a);
    if (b) begin
      m_pc_reg = a & 32'hFFFF_FFFC;
      m_pc     = 32'h0;
      m_instr  = NOP_INSTR;
      m_valid  = 1'b0;
    end else if (!f) begin
      m_instr  = fetch_word(m_pc_reg);
      m_pc_reg = m_pc_reg + 32'd4;
      m_pc     = m_pc_reg;
      m_valid  = 1'b1;
      m_count  = m_count + 32'd1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},    PC,            m_pc);
    check({tag, ".instr"}, instruction,   m_instr);
    check({tag, ".valid"}, {31'b0, valid}, {31'b0, m_valid});
    check({tag, ".count"}, fetchCount,    m_count);
  endtask

  // Inputs change 1 time unit after a rising edge and are sampled at the next one.
  task automatic step(input string tag, input logic f, input logic b, input logic [31:0] a);
    freeze      = f;
    branchTaken = b;
    branchAddr  = a;
    @(posedge clk);
    model_edge(f, b, a);
    #1;
    check_all(tag);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      rom[i] = (i == 0) ? 32'hE3A0_0014 : $urandom;
      dut.u_imem.mem[i] = rom[i];
    end
    rst         = 1'b0;
    freeze      = 1'b0;
    branchTaken = 1'b0;
    branchAddr  = 32'h0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b1;

    step("first", 1'b0, 1'b0, 32'h0);
    check("first.rom0", instruction, 32'hE3A0_0014);
    check("first.pc4",  PC,          32'h4);
    for (int i = 0; i < 3; i++) step("run", 1'b0, 1'b0, 32'h0);
    check("run.count4", fetchCount, 32'd4);

    for (int i = 0; i < 3; i++) step("freeze", 1'b1, 1'b0, 32'h0);
    step("release", 1'b0, 1'b0, 32'h0);

    step("br40.bubble", 1'b0, 1'b1, 32'h40);
    check("br40.nop", instruction, NOP_INSTR);
    step("br40.fetch", 1'b0, 1'b0, 32'h0);
    check("br40.pc44", PC, 32'h44);

    step("brfz.bubble", 1'b1, 1'b1, 32'h23);
    step("brfz.fetch",  1'b0, 1'b0, 32'h0);
    check("brfz.pc24", PC, 32'h24);

    step("rom.edge.br", 1'b0, 1'b1, 32'h5C);
    step("rom.last",    1'b0, 1'b0, 32'h0);
    step("rom.beyond",  1'b0, 1'b0, 32'h0);
    check("rom.beyond.nop", instruction, NOP_INSTR);

    step("wrap.br",    1'b0, 1'b1, 32'hFFFF_FFFE);
    step("wrap.fetch", 1'b0, 1'b0, 32'h0);
    step("wrap.next",  1'b0, 1'b0, 32'h0);

    step("pre_rst.br",  1'b0, 1'b1, 32'h40);
    step("pre_rst.run", 1'b0, 1'b0, 32'h0);
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_held");
    rst = 1'b1;
    step("restart", 1'b0, 1'b0, 32'h0);

    for (int i = 0; i < 200; i++) begin
      logic        f, b;
      logic [31:0] a;
      f = ($urandom_range(3) == 0);
      b = ($urandom_range(7) == 0);
      a = ($urandom_range(9) == 0) ? $urandom : 32'($urandom_range(255));
      step("rand", f, b, a);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
